// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared types for the pipeline hazard controller.
//   hz_state_t : sequencer states (normal run, data wait, halt drain, halted)
//   regbits_t  : 5-bit architectural register select
//   REG_ZERO   : register 0, which never carries a real dependency
// ----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } hz_state_t;

    typedef logic [4:0] regbits_t;

    localparam regbits_t REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the datapath and the hazard controller.
//   Datapath -> controller : ihit, dhit, mem_dREN, mem_dWEN, ex_MemRead,
//                            ex_wsel, id_rs, id_rt, ex_redirect, mem_halt,
//                            wrb_halt
//   Controller -> datapath : pc_en, per-latch en/flush, halt, stall_cycles
// master = datapath side, slave = controller side.
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipeline_hazard_ctrl_pkg::*;

    logic             ihit;
    logic             dhit;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic             ex_MemRead;
    regbits_t         ex_wsel;
    regbits_t         id_rs;
    regbits_t         id_rt;
    logic             ex_redirect;
    logic             mem_halt;
    logic             wrb_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, ex_MemRead, ex_wsel,
               id_rs, id_rt, ex_redirect, mem_halt, wrb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt, stall_cycles
    );

    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, ex_MemRead, ex_wsel,
               id_rs, id_rt, ex_redirect, mem_halt, wrb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt, stall_cycles
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_hazard_detect
// Combinational load-use / redirect comparator.
//   i_ex_MemRead  : ID/EX holds a load
//   i_ex_wsel     : ID/EX destination register
//   i_id_rs/rt    : IF/ID source registers
//   i_ex_redirect : taken branch/jump resolved in EX
//   o_load_use    : load-use stall required (already masked by redirect)
//   o_redirect    : redirect request
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic     i_ex_MemRead,
    input  regbits_t i_ex_wsel,
    input  regbits_t i_id_rs,
    input  regbits_t i_id_rt,
    input  logic     i_ex_redirect,
    output logic     o_load_use,
    output logic     o_redirect
);

    logic w_dep;

    // A load into r0 never produces a usable value, so it cannot stall.
    assign w_dep = i_ex_MemRead && (i_ex_wsel != REG_ZERO) &&
                   ((i_ex_wsel == i_id_rs) || (i_ex_wsel == i_id_rt));

    // A redirect squashes the dependent instruction, so no stall is needed.
    assign o_load_use = w_dep && !i_ex_redirect;
    assign o_redirect = i_ex_redirect;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
//   CLK  : system clock
//   nRST : asynchronous active-low reset
//   bus  : controller side of pipeline_hazard_ctrl_if (hazard inputs in,
//          PC enable, latch en/flush, halt flag and stall counter out)
// Enables and flushes are combinational from state and inputs; only the
// state, the sticky halt flag and the stall counter are registered.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic             r_halt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_redirect;
    logic w_mem_access;
    logic w_pc_en;
    logic w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
    logic w_ifid_flush, w_idex_flush, w_exmem_flush, w_memwb_flush;

    pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
        .i_ex_MemRead  (bus.ex_MemRead),
        .i_ex_wsel     (bus.ex_wsel),
        .i_id_rs       (bus.id_rs),
        .i_id_rt       (bus.id_rt),
        .i_ex_redirect (bus.ex_redirect),
        .o_load_use    (w_load_use),
        .o_redirect    (w_redirect)
    );

    assign w_mem_access = bus.mem_dREN || bus.mem_dWEN;

    // Priority chain: reset > HALTED > data access > halt drain >
    // redirect > load-use > instruction miss.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_memwb_en    = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_memwb_flush = 1'b0;

        if (!nRST) begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_en    = 1'b0;
            w_memwb_en    = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
            w_memwb_flush = 1'b1;
        end else if (r_state == HALTED) begin
            w_pc_en    = 1'b0;
            w_ifid_en  = 1'b0;
            w_idex_en  = 1'b0;
            w_exmem_en = 1'b0;
            w_memwb_en = 1'b0;
        end else if ((r_state == DWAIT) || ((r_state == RUN) && w_mem_access)) begin
            if (bus.dhit) begin
                // Access completes: back end advances, fetch slot is bubbled
                // because the PC held while the access was in flight.
                w_pc_en      = 1'b0;
                w_ifid_flush = 1'b1;
                w_state_nxt  = RUN;
            end else begin
                w_pc_en     = 1'b0;
                w_ifid_en   = 1'b0;
                w_idex_en   = 1'b0;
                w_exmem_en  = 1'b0;
                w_memwb_en  = 1'b0;
                w_state_nxt = DWAIT;
            end
        end else if ((r_state == DRAIN) || bus.mem_halt) begin
            // Only the halting instruction continues toward writeback.
            w_pc_en       = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
            w_state_nxt   = ((r_state == DRAIN) && bus.wrb_halt) ? HALTED : DRAIN;
        end else if (w_redirect) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
        end else if (!bus.ihit) begin
            w_pc_en      = 1'b0;
            w_ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= RUN;
            r_halt      <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == HALTED) begin
                r_halt <= 1'b1;
            end
            if (!w_pc_en && (r_state != HALTED) && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    assign bus.pc_en        = w_pc_en;
    assign bus.ifid_en      = w_ifid_en;
    assign bus.idex_en      = w_idex_en;
    assign bus.exmem_en     = w_exmem_en;
    assign bus.memwb_en     = w_memwb_en;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.idex_flush   = w_idex_flush;
    assign bus.exmem_flush  = w_exmem_flush;
    assign bus.memwb_flush  = w_memwb_flush;
    assign bus.halt         = r_halt;
    assign bus.stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Two controllers (32-bit and 4-bit stall counters) share one stimulus
// stream. A reference model describes each latch as hold / advance / bubble
// and pushes the expected response per cycle; a monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       rst_n;
        logic       ihit;
        logic       dhit;
        logic       dren;
        logic       dwen;
        logic       memread;
        logic [4:0] wsel;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       redirect;
        logic       mhalt;
        logic       whalt;
    } stim_t;

    typedef struct {
        logic [8:0]  ctl;
        logic        halt;
        logic [31:0] c32;
        logic [3:0]  c4;
        int          cyc;
    } exp_t;

    localparam int A_HOLD = 0;
    localparam int A_ADV  = 1;
    localparam int A_BUB  = 2;
    localparam int A_RST  = 3;

    logic  CLK = 1'b0;
    logic  nRST;
    stim_t cur;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) if32 ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  if4 ();

    assign nRST             = cur.rst_n;
    assign if32.ihit        = cur.ihit;
    assign if32.dhit        = cur.dhit;
    assign if32.mem_dREN    = cur.dren;
    assign if32.mem_dWEN    = cur.dwen;
    assign if32.ex_MemRead  = cur.memread;
    assign if32.ex_wsel     = cur.wsel;
    assign if32.id_rs       = cur.rs;
    assign if32.id_rt       = cur.rt;
    assign if32.ex_redirect = cur.redirect;
    assign if32.mem_halt    = cur.mhalt;
    assign if32.wrb_halt    = cur.whalt;
    assign if4.ihit         = cur.ihit;
    assign if4.dhit         = cur.dhit;
    assign if4.mem_dREN     = cur.dren;
    assign if4.mem_dWEN     = cur.dwen;
    assign if4.ex_MemRead   = cur.memread;
    assign if4.ex_wsel      = cur.wsel;
    assign if4.id_rs        = cur.rs;
    assign if4.id_rt        = cur.rt;
    assign if4.ex_redirect  = cur.redirect;
    assign if4.mem_halt     = cur.mhalt;
    assign if4.wrb_halt     = cur.whalt;

    pipeline_hazard_ctrl #(.CNT_W(32)) dut32 (.CLK(CLK), .nRST(nRST), .bus(if32));
    pipeline_hazard_ctrl #(.CNT_W(4))  dut4  (.CLK(CLK), .nRST(nRST), .bus(if4));

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cycn  = 0;

    // Model: core is either flowing, waiting on data, draining, or stopped.
    bit              m_wait  = 1'b0;
    bit              m_drain = 1'b0;
    bit              m_stop  = 1'b0;
    longint unsigned m_c32   = 0;
    int              m_c4    = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp, input int cyc);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        int   act[4];
        bit   pc;
        bit   was_stopped;
        @(negedge CLK);
        cur = s;
        cycn++;
        e.cyc  = cycn;
        e.halt = m_stop;
        e.c32  = m_c32[31:0];
        e.c4   = m_c4[3:0];
        was_stopped = m_stop;
        pc = 1'b1;
        for (int i = 0; i < 4; i++) act[i] = A_ADV;
        if (!s.rst_n) begin
            pc = 1'b0;
            for (int i = 0; i < 4; i++) act[i] = A_RST;
            m_wait = 0; m_drain = 0; m_stop = 0; m_c32 = 0; m_c4 = 0;
            e.halt = 1'b0; e.c32 = '0; e.c4 = '0;
        end else begin
            if (m_stop) begin
                pc = 1'b0;
                for (int i = 0; i < 4; i++) act[i] = A_HOLD;
            end else if (m_wait || (!m_drain && (s.dren || s.dwen))) begin
                pc = 1'b0;
                if (s.dhit) begin
                    act[0] = A_BUB;
                    m_wait = 1'b0;
                end else begin
                    for (int i = 0; i < 4; i++) act[i] = A_HOLD;
                    m_wait = 1'b1;
                end
            end else if (m_drain || s.mhalt) begin
                pc = 1'b0;
                act[0] = A_BUB; act[1] = A_BUB; act[2] = A_BUB;
                if (m_drain && s.whalt) begin
                    m_drain = 1'b0;
                    m_stop  = 1'b1;
                end else begin
                    m_drain = 1'b1;
                end
            end else if (s.redirect) begin
                act[0] = A_BUB; act[1] = A_BUB;
            end else if (s.memread && s.wsel != 5'd0 && (s.wsel == s.rs || s.wsel == s.rt)) begin
                pc = 1'b0;
                act[0] = A_HOLD; act[1] = A_BUB;
            end else if (!s.ihit) begin
                pc = 1'b0;
                act[0] = A_BUB;
            end
            if (!was_stopped && !pc) begin
                if (m_c32 < 64'hFFFF_FFFF) m_c32 = m_c32 + 1;
                if (m_c4 < 15) m_c4 = m_c4 + 1;
            end
        end
        e.ctl[8] = pc;
        for (int i = 0; i < 4; i++) begin
            e.ctl[7-i] = (act[i] == A_ADV) || (act[i] == A_BUB);
            e.ctl[3-i] = (act[i] == A_BUB) || (act[i] == A_RST);
        end
        sbq.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        s.ihit  = 1'b1;
        return s;
    endfunction

    function automatic stim_t rnd(input bit allow_halt, input bit allow_rst);
        stim_t s;
        s.rst_n    = !(allow_rst && ($urandom_range(0, 49) == 0));
        s.ihit     = ($urandom_range(0, 9) < 8);
        s.dhit     = 1'($urandom_range(0, 1));
        s.dren     = ($urandom_range(0, 7) == 0);
        s.dwen     = ($urandom_range(0, 9) == 0);
        s.memread  = ($urandom_range(0, 2) == 0);
        s.wsel     = 5'($urandom_range(0, 3));
        s.rs       = 5'($urandom_range(0, 3));
        s.rt       = 5'($urandom_range(0, 3));
        s.redirect = ($urandom_range(0, 9) == 0);
        s.mhalt    = allow_halt && ($urandom_range(0, 39) == 0);
        s.whalt    = ($urandom_range(0, 2) == 0);
        return s;
    endfunction

    // Monitor: combinational outputs are settled 1 time unit after the
    // falling edge at which the stimulus for the cycle was applied.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("ctl32", 32'({if32.pc_en, if32.ifid_en, if32.idex_en, if32.exmem_en,
                                   if32.memwb_en, if32.ifid_flush, if32.idex_flush,
                                   if32.exmem_flush, if32.memwb_flush}), 32'(e.ctl), e.cyc);
                check("ctl4", 32'({if4.pc_en, if4.ifid_en, if4.idex_en, if4.exmem_en,
                                  if4.memwb_en, if4.ifid_flush, if4.idex_flush,
                                  if4.exmem_flush, if4.memwb_flush}), 32'(e.ctl), e.cyc);
                check("halt", 32'(if32.halt), 32'(e.halt), e.cyc);
                check("stall32", if32.stall_cycles, e.c32, e.cyc);
                check("stall4", 32'(if4.stall_cycles), 32'(e.c4), e.cyc);
            end
        end
    end

    initial begin
        stim_t s;
        cur = '0;

        // reset, then normal flow
        repeat (2) begin s = rnd(1'b1, 1'b0); s.rst_n = 1'b0; apply(s); end
        repeat (3) apply(idle());

        // data miss for three cycles, then hit
        s = idle(); s.dren = 1'b1;
        repeat (3) apply(s);
        s.dhit = 1'b1; apply(s);
        apply(idle());

        // load-use on rt, then same with r0 destination
        s = idle(); s.memread = 1'b1; s.wsel = 5'd5; s.rt = 5'd5; apply(s);
        apply(idle());
        s.wsel = 5'd0; s.rt = 5'd0; s.rs = 5'd0; apply(s);

        // load-use overridden by redirect
        s = idle(); s.memread = 1'b1; s.wsel = 5'd7; s.rs = 5'd7; s.redirect = 1'b1; apply(s);

        // reset in the middle of a data wait
        s = idle(); s.dwen = 1'b1; repeat (2) apply(s);
        s.rst_n = 1'b0; apply(s);
        repeat (2) apply(idle());

        // instruction miss long enough to saturate the 4-bit counter
        s = idle(); s.ihit = 1'b0; repeat (20) apply(s);

        // mixed random traffic including halts and resets
        repeat (400) apply(rnd(1'b1, 1'b1));

        // halt sequence: mem_halt, drain, wrb_halt, then ten halted cycles
        s = idle(); s.rst_n = 1'b0; apply(s);
        repeat (2) apply(idle());
        s = idle(); s.mhalt = 1'b1; apply(s);
        apply(idle());
        s = idle(); s.whalt = 1'b1; apply(s);
        repeat (10) apply(rnd(1'b1, 1'b0));

        repeat (3) @(negedge CLK);
        #2;
        check("sb_empty", 32'(sbq.size()), 32'd0, cycn);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline latches: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Drives every latch's EN and flush, plus PC enable, from cache hits, load-use hazards, control redirects and halt.
- Owns a small FSM for outstanding data accesses and halt drain, plus a saturating stall-cycle counter for per-core performance readout.
- Sits beside the datapath; one instance per core.

Parameters:
- CNT_W, 32, width of stall-cycle counter.

Ports:
- CLK  input  1  system clock.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction fetch completed this cycle.
- dhit  input  1  data access completed this cycle.
- mem_dREN  input  1  EX/MEM holds a load.
- mem_dWEN  input  1  EX/MEM holds a store.
- ex_MemRead  input  1  ID/EX holds a load.
- ex_wsel  input  5  ID/EX destination register.
- id_rs  input  5  IF/ID source register rs.
- id_rt  input  5  IF/ID source register rt.
- ex_redirect  input  1  taken branch/jump resolved in EX.
- mem_halt  input  1  halt at MEM/WB input.
- wrb_halt  input  1  halt at MEM/WB output.
- pc_en  output  1  PC update enable.
- ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  latch bubble insert (asserted together with en).
- halt  output  1  sticky core-halted flag.
- stall_cycles  output  CNT_W  cycles with pc_en=0 while not HALTED.

Behaviour:
- Clock and reset: one clock CLK; reset nRST is asynchronous, active-low.
- Reset values: state=RUN, halt=0, stall_cycles=0. While nRST=0: all en=0, all flush=1.
- States: RUN, DWAIT, DRAIN, HALTED.
- Default in RUN (ihit=1, no hazard): all en=1, all flush=0.
- Data access outstanding: mem_dREN|mem_dWEN and dhit=0 in RUN -> all en=0, go to DWAIT.
  - DWAIT holds all en=0 until dhit.
  - On dhit: EX/MEM and MEM/WB advance; pc_en=0; IF/ID flush; ID/EX advances. Then -> RUN.
- Data hit in RUN: mem access with dhit=1 in RUN behaves identically to the DWAIT exit cycle (no state change).
- Halt: mem_halt=1 -> pc_en=0; ifid/idex/exmem flush; memwb_en=1; -> DRAIN.
  - DRAIN: pc_en=0, front three latches flushed, memwb_en=1.
  - wrb_halt=1 -> HALTED.
- HALTED: all en=0, halt=1, counter frozen. Exit only by reset.
- Redirect: ex_redirect=1 -> ifid_flush=1, idex_flush=1, pc_en=1.
- Load-use hazard: ex_MemRead & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt).
  - Response: pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble.
- Instruction miss: ihit=0 -> pc_en=0, ifid_flush=1, downstream advance.
- Priority, highest first: reset > HALTED > data stall/DWAIT > halt/DRAIN > redirect > load-use > ihit miss.
  - Redirect overrides load-use: the dependent instruction is squashed.
- Counter: +1 on each cycle pc_en=0 and state!=HALTED; saturates at all-ones; no wrap.
- Outputs: combinational from state and inputs. Only the state register, halt and the counter are registered.
- Reset mid-DWAIT or mid-DRAIN: immediate return to reset values; no pending access is remembered.

Decomposition:
- cpu_types_pkg gains:
  - hz_state_t enum {RUN, DWAIT, DRAIN, HALTED}.
  - regbits_t (5-bit) for register selects, if not already present.
- Sub-module: hazard_detect, a combinational load-use/redirect comparator.
- The FSM and counter stay in the top module.

Test Plan:
- Reset with nRST=0 mid-run -> all en=0, all flush=1, stall_cycles=0, halt=0; after release with ihit=1 -> all en=1, no flush.
- mem_dREN=1, dhit=0 for 3 cycles then dhit=1 -> 3 cycles all en=0 in DWAIT; exit cycle exmem_en=memwb_en=1, ifid_flush=1, pc_en=0; stall_cycles=4.
- ex_MemRead=1, ex_wsel=5, id_rt=5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; same with ex_wsel=0 -> no stall.
- Load-use and ex_redirect together -> ifid_flush=1, idex_flush=1, pc_en=1, stall_cycles unchanged.
- mem_halt=1, then wrb_halt=1 two cycles later -> DRAIN with front flushed; then HALTED with halt=1 and all en=0 for 10 cycles; counter frozen.
- CNT_W=4 with ihit=0 for 20 cycles -> stall_cycles saturates at 15.
